// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave returns the sum.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic used by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, carry fed back through a register.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;
  logic             r_busy;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_full_adder (
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .c     (r_carry),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // New bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_carry;
          r_cnt    <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_fa_carry;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 8 and 16.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation; call at posedge+1. Start is sampled at the next edge (cycle 0).
  task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [15:0] s, output logic co,
                        output int n_done, output int first_done, output int n_busy);
    int   w;
    logic bz;
    logic dn;
    w = wide ? 16 : 8;
    if (wide) begin
      bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = cin;
    end else begin
      bus8.start = 1'b1; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.cin = cin;
    end
    @(posedge clk); #1;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    s = 'x; co = 1'bx; n_done = 0; first_done = -1; n_busy = 0;
    for (int c = 1; c <= w + 6; c++) begin
      bz = wide ? bus16.busy : bus8.busy;
      dn = wide ? bus16.done : bus8.done;
      if (bz) n_busy++;
      if (dn) begin
        n_done++;
        if (first_done < 0) first_done = c;
        s  = wide ? bus16.sum : {8'h00, bus8.sum};
        co = wide ? bus16.cout : bus8.cout;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus8.busy); end
    total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus8.done); end
    total++; if (bus8.sum !== 8'h00) begin bad++; $display("FAIL reset_sum: got %h want 00", bus8.sum); end
    total++; if (bus8.cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b want 0", bus8.cout); end
    total++; if (bus16.sum !== 16'h0000 || bus16.busy !== 1'b0) begin
      bad++; $display("FAIL reset_w16: got sum=%h busy=%b want 0000/0", bus16.sum, bus16.busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    logic [15:0] s; logic co; int nd, fd, nb;
    run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, s, co, nd, fd, nb);
    total++; if (s[7:0] !== 8'h00) begin bad++; $display("FAIL chain_sum: got %h want 00", s[7:0]); end
    total++; if (co !== 1'b1) begin bad++; $display("FAIL chain_cout: got %b want 1", co); end
    total++; if (nd !== 1) begin bad++; $display("FAIL chain_done_count: got %0d want 1", nd); end
    total++; if (fd !== 9) begin bad++; $display("FAIL chain_done_cycle: got %0d want 9", fd); end
    total++; if (nb !== 9) begin bad++; $display("FAIL chain_busy_cycles: got %0d want 9", nb); end
  endtask

  task automatic test_carry_in();
    logic [15:0] s; logic co; int nd, fd, nb;
    run_op(1'b0, 16'h005A, 16'h00A5, 1'b1, s, co, nd, fd, nb);
    total++; if (s[7:0] !== 8'h00 || co !== 1'b1) begin
      bad++; $display("FAIL cin1: got cout=%b sum=%h want 1/00", co, s[7:0]);
    end
    run_op(1'b0, 16'h005A, 16'h00A5, 1'b0, s, co, nd, fd, nb);
    total++; if (s[7:0] !== 8'hFF || co !== 1'b0) begin
      bad++; $display("FAIL cin0: got cout=%b sum=%h want 0/ff", co, s[7:0]);
    end
  endtask

  task automatic test_start_while_busy();
    int nd, fd;
    logic [7:0] s; logic co;
    bus8.start = 1'b1; bus8.a = 8'h03; bus8.b = 8'h04; bus8.cin = 1'b0;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    nd = 0; fd = -1; s = 'x; co = 1'bx;
    for (int c = 1; c <= 24; c++) begin
      if (c == 4) begin bus8.start = 1'b1; bus8.a = 8'hFF; end
      if (c == 5) bus8.start = 1'b0;
      if (bus8.done) begin
        nd++;
        if (fd < 0) fd = c;
        s = bus8.sum; co = bus8.cout;
      end
      @(posedge clk); #1;
    end
    total++; if (s !== 8'h07 || co !== 1'b0) begin
      bad++; $display("FAIL busy_start_result: got cout=%b sum=%h want 0/07", co, s);
    end
    total++; if (nd !== 1 || fd !== 9) begin
      bad++; $display("FAIL busy_start_done: got count=%0d cycle=%0d want 1/9", nd, fd);
    end
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle: got %b want 0", bus8.busy); end
  endtask

  task automatic test_reset_mid();
    int nd, fd, nb;
    logic [15:0] s; logic co;
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h3C; bus8.cin = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
      bad++; $display("FAIL midreset_ctrl: got busy=%b done=%b want 0/0", bus8.busy, bus8.done);
    end
    total++; if (bus8.sum !== 8'h00 || bus8.cout !== 1'b0) begin
      bad++; $display("FAIL midreset_result: got cout=%b sum=%h want 0/00", bus8.cout, bus8.sum);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus8.done) nd++;
      @(posedge clk); #1;
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d want 0", nd); end
    run_op(1'b0, 16'h0010, 16'h0020, 1'b0, s, co, nd, fd, nb);
    total++; if (s[7:0] !== 8'h30 || co !== 1'b0) begin
      bad++; $display("FAIL midreset_after: got cout=%b sum=%h want 0/30", co, s[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] op_a [3];
    logic [7:0] op_b [3];
    logic       op_c [3];
    logic [8:0] exp_r [3];
    int idx;
    op_a = '{8'h12, 8'h80, 8'hC8};
    op_b = '{8'h34, 8'h80, 8'h64};
    op_c = '{1'b0, 1'b1, 1'b0};
    exp_r = '{9'h046, 9'h101, 9'h12C};
    idx = 0;
    bus8.start = 1'b1; bus8.a = op_a[0]; bus8.b = op_b[0]; bus8.cin = op_c[0];
    @(posedge clk); #1;
    for (int c = 1; c <= 40; c++) begin
      if (bus8.done) begin
        if (idx < 3) begin
          total++; if ({bus8.cout, bus8.sum} !== exp_r[idx] || c !== 9 + 10 * idx) begin
            bad++;
            $display("FAIL b2b_op%0d: got result=%h cycle=%0d want %h/%0d",
                     idx, {bus8.cout, bus8.sum}, c, exp_r[idx], 9 + 10 * idx);
          end
        end
        idx++;
        if (idx < 3) begin
          bus8.a = op_a[idx]; bus8.b = op_b[idx]; bus8.cin = op_c[idx];
        end else begin
          bus8.start = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    bus8.start = 1'b0;
    total++; if (idx !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", idx); end
  endtask

  task automatic test_random(input bit wide);
    logic [15:0] a, b, s;
    logic        c, co;
    logic [16:0] exp_r;
    int nd, fd, nb;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (!wide) begin
        a[15:8] = 8'h00;
        b[15:8] = 8'h00;
      end
      if (wide) exp_r = {1'b0, a} + {1'b0, b} + {16'h0000, c};
      else      exp_r = {8'h00, ({1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, c})};
      run_op(wide, a, b, c, s, co, nd, fd, nb);
      if (wide) begin
        total++; if ({co, s} !== exp_r) begin
          bad++; $display("FAIL rand16_%0d: a=%h b=%h cin=%b got %h want %h", i, a, b, c, {co, s}, exp_r);
        end
      end else begin
        total++; if ({co, s[7:0]} !== exp_r[8:0]) begin
          bad++;
          $display("FAIL rand8_%0d: a=%h b=%h cin=%b got %h want %h", i, a[7:0], b[7:0], c,
                   {co, s[7:0]}, exp_r[8:0]);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_carry_chain();
    test_carry_in();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
